// File: rtl/sdram_block_mem.sv
// Byte-wide SDRAM-side backing store with fixed-latency pipelined reads.
// Optional periodic refresh that holds off strobes is compiled in with `define SDRAM_REFRESH_EN.
module sdram_block_mem #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int READ_LATENCY   = 4,
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] Address_sdram,
    input  logic                  wr_rd_sdram,
    input  logic                  mstrb_sdram,
    input  logic [DATA_WIDTH-1:0] din_sdram,
    output logic [DATA_WIDTH-1:0] DOut_sdram,
    output logic                  dvalid_sdram,
    output logic                  busy_sdram
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (READ_LATENCY < 1 || READ_LATENCY > 16) begin : g_bad_latency
        $error("sdram_block_mem: READ_LATENCY must be within 1..16");
    end
    if (REFRESH_PERIOD < 1 || REFRESH_CYCLES < 1) begin : g_bad_refresh
        $error("sdram_block_mem: REFRESH_PERIOD and REFRESH_CYCLES must be positive");
    end

    logic accept;
    logic wr_accept;
    logic rd_accept;

    assign accept    = mstrb_sdram && !busy_sdram;
    assign wr_accept = accept && wr_rd_sdram;
    assign rd_accept = accept && !wr_rd_sdram;

    // NOTE: the store is deliberately left out of reset; clearing a RAM on reset
    // is not possible in a block memory and rst must not disturb its contents.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[Address_sdram] <= din_sdram;
        end
    end

    // Read pipeline: only the valid bits need reset; data is qualified by them.
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_dat[0] <= mem[Address_sdram];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    // Output stage adds the final edge of latency and holds the last returned byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DOut_sdram   <= '0;
            dvalid_sdram <= 1'b0;
        end else begin
            dvalid_sdram <= pipe_vld[READ_LATENCY-1];
            if (pipe_vld[READ_LATENCY-1]) begin
                DOut_sdram <= pipe_dat[READ_LATENCY-1];
            end
        end
    end

`ifdef SDRAM_REFRESH_EN
    typedef enum logic {
        IDLE,
        REFRESH
    } state_t;

    localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(REFRESH_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One counter times both phases; it restarts at every state change.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            IDLE: begin
                if (cnt == PERIOD_LAST) begin
                    state_nxt = REFRESH;
                    cnt_nxt   = '0;
                end
            end
            REFRESH: begin
                if (cnt == BUSY_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign busy_sdram = (state == REFRESH);
`else
    assign busy_sdram = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_block_mem.sv
// Self-checking bench for sdram_block_mem: directed table, burst, reset and refresh
// sequences plus randomized traffic against a queue-based reference model.
module tb_sdram_block_mem;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int P  = 16;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mstrb = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          busy;

    sdram_block_mem #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .READ_LATENCY  (L),
        .REFRESH_PERIOD(P),
        .REFRESH_CYCLES(C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Address_sdram(addr),
        .wr_rd_sdram  (wr),
        .mstrb_sdram  (mstrb),
        .din_sdram    (din),
        .DOut_sdram   (dout),
        .dvalid_sdram (dvalid),
        .busy_sdram   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
    } ret_t;

    // Reference model: flat byte array plus a queue of returns keyed by due edge.
    bit   [DW-1:0] ref_mem [0:(1<<AW)-1];
    ret_t          rq [$];
    int unsigned   edge_n = 0;
    int unsigned   cyc = 0;
    logic [DW-1:0] exp_dout = '0;
    bit            cur_use_exp = 1'b0;
    logic [DW-1:0] cur_exp = '0;
    int            checks = 0;
    int            failures = 0;

    // Busy pattern from release of reset: P idle cycles then C busy cycles, repeating.
    function automatic bit exp_busy(input int unsigned c);
`ifdef SDRAM_REFRESH_EN
        return (c % (P + C)) >= P;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit   acc;
        bit   exp_v;
        ret_t r;
        acc = rst && mstrb && !exp_busy(cyc);
        @(posedge clk);
        edge_n++;
        if (acc) begin
            if (wr) begin
                ref_mem[addr] = din;
            end else begin
                r.due  = edge_n + L;
                r.data = cur_use_exp ? cur_exp : ref_mem[addr];
                rq.push_back(r);
            end
        end
        if (rst) cyc++;
        #1;
        exp_v = (rq.size() > 0) && (rq[0].due == edge_n);
        if (exp_v) begin
            exp_dout = rq[0].data;
            void'(rq.pop_front());
        end
        check("dvalid", 32'(dvalid), 32'(exp_v));
        check("dout", 32'(dout), 32'(exp_dout));
        check("busy", 32'(busy), 32'(exp_busy(cyc)));
    endtask

    task automatic idle();
        mstrb = 1'b0;
        cycle();
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit use_exp, input logic [DW-1:0] e, input bit force_now);
        int guard;
        guard = 0;
        while (!force_now && exp_busy(cyc) && guard < 64) begin
            idle();
            guard++;
        end
        mstrb = 1'b1;
        wr = w;
        addr = a;
        din = d;
        cur_use_exp = use_exp;
        cur_exp = e;
        cycle();
        mstrb = 1'b0;
        cur_use_exp = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        mstrb = 1'b0;
        rq.delete();
        exp_dout = '0;
        #1;
        check("rst_dvalid", 32'(dvalid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (n) cycle();
        rst = 1'b1;
        cyc = 0;
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b1, 16'h0040, 8'hA5, 8'h00};
        tbl[1]  = '{1'b0, 16'h0040, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 16'h1234, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 16'hFFFF, 8'h3C, 8'h00};
        tbl[4]  = '{1'b1, 16'h0000, 8'hC3, 8'h00};
        tbl[5]  = '{1'b0, 16'hFFFF, 8'h00, 8'h3C};
        tbl[6]  = '{1'b0, 16'h0000, 8'h00, 8'hC3};
        tbl[7]  = '{1'b1, 16'h0040, 8'h5A, 8'h00};
        tbl[8]  = '{1'b0, 16'h0040, 8'h00, 8'h5A};
        tbl[9]  = '{1'b1, 16'h0041, 8'hFF, 8'h00};
        tbl[10] = '{1'b0, 16'h0041, 8'h00, 8'hFF};
        tbl[11] = '{1'b0, 16'h0040, 8'h00, 8'h5A};

        #2;
        apply_reset(3);

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].wr, tbl[i].addr, tbl[i].din, !tbl[i].wr, tbl[i].exp, 1'b0);
        end
        repeat (L + 2) idle();

        // Burst fill then back-to-back reads; returns must be contiguous and in order.
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, AW'(16'h0100 + i), DW'(i), 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            issue(1'b0, AW'(16'h0100 + i), '0, 1'b1, DW'(i), 1'b0);
        end
        repeat (L + 2) idle();

        // Reset with reads in flight: none may return and outputs must clear.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, AW'(16'h0110 + i), '0, 1'b0, '0, 1'b0);
        end
        apply_reset(3);
        repeat (L + 4) idle();

`ifdef SDRAM_REFRESH_EN
        // Read just before refresh onset returns on schedule; write during busy is dropped.
        for (int g = 0; g < 2 * (P + C) && (cyc % (P + C)) != P - 1; g++) idle();
        issue(1'b0, 16'h0040, '0, 1'b1, 8'h5A, 1'b1);
        issue(1'b1, 16'h0005, 8'h77, 1'b0, '0, 1'b1);
        issue(1'b0, 16'h0005, '0, 1'b1, 8'h00, 1'b0);
        repeat (L + 2) idle();
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 1) == 0) a = AW'(16'h0100 + $urandom_range(0, 63));
            else                           a = AW'($urandom_range(16'h0200, 16'hFFFF));
            mstrb = ($urandom_range(0, 3) != 0);
            wr = 1'($urandom_range(0, 1));
            addr = a;
            din = DW'($urandom);
            cycle();
        end
        repeat (L + 4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
